// File: rtl/access_arbiter_n.sv
//==============================================================================
// Module   : access_arbiter_n
// Brief    : N-terminal permission checker with round-robin, time-bounded
//            grants of the matrix and LED decoders.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module access_arbiter_n #(
  parameter int                              N_CH        = 2,
  parameter int                              ID_W        = 3,
  parameter int                              FN_W        = 3,
  parameter int                              HOLD_CYCLES = 8,
  parameter logic [2**ID_W-1:0]              TARGET_MAP  = 8'hF0,
  parameter logic [2**ID_W*2**FN_W-1:0]      PERM_TABLE  = {8{8'hFE}},
  localparam int                             OWN_W       = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_CH-1:0]        REQ,
  input  logic [N_CH*ID_W-1:0]   UID,
  input  logic [N_CH*FN_W-1:0]   FUNC,
  output logic [N_CH-1:0]        ACK,
  output logic [N_CH-1:0]        DENY,
  output logic [FN_W-1:0]        OUT_MATRIZ_CODE,
  output logic [FN_W-1:0]        OUT_LEDS_CODE,
  output logic [OWN_W-1:0]       MATRIZ_OWNER,
  output logic [OWN_W-1:0]       LEDS_OWNER,
  output logic                   MATRIZ_BUSY,
  output logic                   LEDS_BUSY
);

  localparam int                 CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int                 SUM_W = OWN_W + 1;
  localparam logic [SUM_W-1:0]   N_SUM = SUM_W'(N_CH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  logic [N_CH-1:0][ID_W-1:0] uid_vec;
  logic [N_CH-1:0][FN_W-1:0] fn_vec;
  logic [N_CH-1:0]           valid;
  logic [N_CH-1:0]           tgt_leds;
  logic [N_CH-1:0]           ack_q;
  logic [N_CH-1:0]           deny_q;

  assign uid_vec = UID;
  assign fn_vec  = FUNC;

  for (genvar i = 0; i < N_CH; i++) begin : g_term
    assign valid[i]    = REQ[i] && (fn_vec[i] != '0) && PERM_TABLE[{uid_vec[i], fn_vec[i]}];
    assign tgt_leds[i] = TARGET_MAP[uid_vec[i]];
  end

  // Target 0 is the matrix decoder, target 1 the LED decoder.
  for (genvar t = 0; t < 2; t++) begin : g_tgt
    logic [N_CH-1:0]  cand;
    state_t           state_q, state_d;
    logic [FN_W-1:0]  code_q, code_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  ack_d;
    logic             found;
    logic [OWN_W-1:0] pick;
    logic [SUM_W-1:0] sum;

    // A terminal already holding a target is masked so a UID change cannot grab the other one.
    assign cand = valid & ~ack_q & ((t == 0) ? ~tgt_leds : tgt_leds);

    always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int k = 0; k < N_CH; k++) begin
        sum = {1'b0, ptr_q} + SUM_W'(k);
        if (sum >= N_SUM) sum = sum - N_SUM;
        if (!found && cand[sum[OWN_W-1:0]]) begin
          found = 1'b1;
          pick  = sum[OWN_W-1:0];
        end
      end
    end

    always_comb begin
      state_d = state_q;
      code_d  = code_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_d = ST_GRANT;
            owner_d = pick;
            code_d  = fn_vec[pick];
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          end
        end
        ST_GRANT: begin
          if (cnt_q == '0 || !REQ[owner_q]) begin
            state_d = ST_RELEASE;
            code_d  = '0;
            busy_d  = 1'b0;
            ptr_d   = (owner_q == OWN_W'(N_CH - 1)) ? '0 : owner_q + OWN_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RELEASE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end

    always_comb begin
      ack_d = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (busy_d && owner_d == OWN_W'(i)) ack_d[i] = 1'b1;
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q <= ST_IDLE;
        code_q  <= '0;
        owner_q <= '0;
        ptr_q   <= '0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        code_q  <= code_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
        busy_q  <= busy_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deny_q <= '0;
      ack_q  <= '0;
    end else begin
      deny_q <= REQ & ~valid;
      ack_q  <= g_tgt[0].ack_d | g_tgt[1].ack_d;
    end
  end

  assign ACK             = ack_q;
  assign DENY            = deny_q;
  assign OUT_MATRIZ_CODE = g_tgt[0].code_q;
  assign OUT_LEDS_CODE   = g_tgt[1].code_q;
  assign MATRIZ_OWNER    = g_tgt[0].owner_q;
  assign LEDS_OWNER      = g_tgt[1].owner_q;
  assign MATRIZ_BUSY     = g_tgt[0].busy_q;
  assign LEDS_BUSY       = g_tgt[1].busy_q;

endmodule

`default_nettype wire

// File: tb/tb_access_arbiter_n.sv
//==============================================================================
// Module   : tb_access_arbiter_n
// Brief    : Directed bench for access_arbiter_n with a cycle-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_access_arbiter_n;

  localparam int          N    = 2;
  localparam int          IDW  = 3;
  localparam int          FNW  = 3;
  localparam int          HOLD = 4;
  localparam logic [63:0] PERM = {8{8'hFE}} & ~(64'd1 << 30);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*IDW-1:0] uid;
  logic [N*FNW-1:0] func;
  logic [N-1:0]     ack, deny;
  logic [FNW-1:0]   mcode, lcode;
  logic [0:0]       mowner, lowner;
  logic             mbusy, lbusy;

  int n_vec = 0;
  int n_err = 0;

  access_arbiter_n #(
    .N_CH(N), .ID_W(IDW), .FN_W(FNW), .HOLD_CYCLES(HOLD),
    .TARGET_MAP(8'hF0), .PERM_TABLE(PERM)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .UID(uid), .FUNC(func),
    .ACK(ack), .DENY(deny), .OUT_MATRIZ_CODE(mcode), .OUT_LEDS_CODE(lcode),
    .MATRIZ_OWNER(mowner), .LEDS_OWNER(lowner), .MATRIZ_BUSY(mbusy), .LEDS_BUSY(lbusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per target, busy/owner/code, cycles held so far, and a one-edge cooldown.
  int           mb[2], mo[2], mc[2], mh[2], mcool[2], mptr[2];
  logic [N-1:0] mdeny, m_elig, m_leds, m_ackpre;
  int           m_fn[N];
  int           m_u, m_f, m_idx;
  bit           m_got;

  function automatic bit allowed(input int u, input int f);
    return (f != 0) && !(u == 3 && f == 6);
  endfunction

  function automatic logic [N-1:0] model_ack();
    logic [N-1:0] a;
    a = '0;
    for (int t = 0; t < 2; t++) if (mb[t] != 0) a[mo[t]] = 1'b1;
    return a;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int t = 0; t < 2; t++) begin
        mb[t] = 0; mo[t] = 0; mc[t] = 0; mh[t] = 0; mcool[t] = 0; mptr[t] = 0;
      end
      mdeny = '0;
    end else begin
      m_ackpre = model_ack();
      for (int i = 0; i < N; i++) begin
        m_u       = int'(uid[i*IDW +: IDW]);
        m_f       = int'(func[i*FNW +: FNW]);
        m_elig[i] = req[i] && allowed(m_u, m_f);
        m_leds[i] = (m_u >= 4);
        m_fn[i]   = m_f;
      end
      mdeny = req & ~m_elig;
      for (int t = 0; t < 2; t++) begin
        if (mb[t] != 0) begin
          mh[t]++;
          if (mh[t] == HOLD || !req[mo[t]]) begin
            mb[t] = 0; mc[t] = 0; mptr[t] = (mo[t] + 1) % N; mcool[t] = 1;
          end
        end else if (mcool[t] > 0) begin
          mcool[t]--;
        end else begin
          m_got = 1'b0;
          for (int k = 0; k < N; k++) begin
            m_idx = (mptr[t] + k) % N;
            if (!m_got && m_elig[m_idx] && !m_ackpre[m_idx] && (m_leds[m_idx] == (t == 1))) begin
              m_got = 1'b1; mb[t] = 1; mo[t] = m_idx; mc[t] = m_fn[m_idx]; mh[t] = 0;
            end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("ack", ack, model_ack());
    check("deny", deny, mdeny);
    check("m_busy", mbusy, mb[0]);
    check("l_busy", lbusy, mb[1]);
    check("m_code", mcode, mc[0]);
    check("l_code", lcode, mc[1]);
    if (mb[0] != 0) check("m_owner", mowner, mo[0]);
    if (mb[1] != 0) check("l_owner", lowner, mo[1]);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_t(input int i, input int u, input int f, input bit r);
    uid[i*IDW +: IDW]  = IDW'(u);
    func[i*FNW +: FNW] = FNW'(f);
    req[i]             = r;
  endtask

  logic [6:0] busy_trace;
  logic [3:0] rr_owners;
  int         grants;
  logic       prev_busy;

  initial begin
    req = '0; uid = '0; func = '0; rst = 1'b0;
    #1 rst = 1'b1;

    // Reset with every request line high.
    set_t(0, 1, 3, 1'b1);
    set_t(1, 0, 0, 1'b1);
    cyc(2);
    check("rst_m_busy", mbusy, 0);
    check("rst_ack", ack, 0);
    check("rst_deny", deny, 0);
    check("rst_m_code", mcode, 0);
    check("rst_m_owner", mowner, 0);
    rst = 1'b0;
    cyc(1);
    check("first_grant_busy", mbusy, 1);
    check("first_grant_code", mcode, 3);
    check("first_grant_ack", ack, 2'b01);
    check("deny_func0", deny, 2'b10);

    // Four busy cycles, RELEASE, IDLE, then re-grant.
    busy_trace[0] = mbusy;
    for (int k = 1; k < 7; k++) begin
      cyc(1);
      busy_trace[k] = mbusy;
    end
    check("hold_trace", busy_trace, 7'b1001111);

    // Reset in the middle of a grant clears outputs at once.
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", mbusy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_code", mcode, 0);

    // Round-robin; the pointer must restart at terminal 0.
    set_t(0, 2, 5, 1'b1);
    set_t(1, 2, 5, 1'b1);
    cyc(1);
    rst       = 1'b0;
    grants    = 0;
    prev_busy = 1'b0;
    rr_owners = '0;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (mbusy && !prev_busy) begin
        rr_owners[grants] = mowner[0];
        grants++;
      end
      prev_busy = mbusy;
      if (grants == 4) break;
    end
    check("rr_grants", grants, 4);
    check("rr_order", rr_owners, 4'b1010);

    // Matrix and LEDs granted on the same edge.
    rst = 1'b1;
    set_t(0, 1, 3, 1'b1);
    set_t(1, 5, 6, 1'b1);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("par_m_busy", mbusy, 1);
    check("par_l_busy", lbusy, 1);
    check("par_m_code", mcode, 3);
    check("par_l_code", lcode, 6);
    check("par_m_owner", mowner, 0);
    check("par_l_owner", lowner, 1);
    check("par_ack", ack, 2'b11);

    // Forbidden function, zero function, then an allowed one.
    rst = 1'b1;
    set_t(0, 3, 6, 1'b1);
    set_t(1, 0, 0, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("deny_perm", deny, 2'b01);
    check("deny_perm_busy", mbusy, 0);
    set_t(0, 3, 0, 1'b1);
    cyc(1);
    check("deny_zero", deny, 2'b01);
    check("deny_zero_busy", mbusy, 0);
    set_t(0, 3, 5, 1'b1);
    cyc(1);
    check("allow_deny", deny, 2'b00);
    check("allow_busy", mbusy, 1);
    check("allow_code", mcode, 5);

    // REQ dropped during the second grant cycle.
    rst = 1'b1;
    set_t(0, 1, 3, 1'b1);
    set_t(1, 0, 0, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check("early_busy_before", mbusy, 1);
    set_t(0, 1, 3, 1'b0);
    cyc(1);
    check("early_busy_after", mbusy, 0);
    check("early_ack_after", ack, 0);
    check("early_code_after", mcode, 0);

    // UID moves to an LED user while the matrix is held.
    rst = 1'b1;
    set_t(0, 1, 3, 1'b1);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    set_t(0, 5, 3, 1'b1);
    cyc(3);
    check("uidchg_l_busy_held", lbusy, 0);
    check("uidchg_m_busy_held", mbusy, 1);
    cyc(1);
    check("uidchg_l_busy_rel", lbusy, 0);
    cyc(1);
    check("uidchg_l_busy", lbusy, 1);
    check("uidchg_l_owner", lowner, 0);
    check("uidchg_l_code", lcode, 3);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
